// File: rtl/fetch_sequencer.sv
// fetch_sequencer: loads a program into a 32-word instruction memory, then
// fetches from it with a byte-address PC that honours stall, branch and halt.
module fetch_sequencer #(
    parameter logic [6:0]  RESET_PC  = 7'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        run_start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [6:0]  branch_target,
    input  logic [31:0] instruction,
    output logic        mem_write_en,
    output logic        mem_mode,
    output logic [4:0]  mem_addr,
    output logic [31:0] mem_data,
    output logic [6:0]  pc,
    output logic        instr_valid,
    output logic [1:0]  state,
    output logic        load_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t      r_state;
    logic [6:0]  r_pc;
    logic [4:0]  r_load_ptr;
    logic        r_load_overflow;

    logic        w_accept;
    logic        w_is_halt;

    assign w_accept  = (r_state == ST_LOAD) && load_valid;
    assign w_is_halt = (instruction == HALT_WORD);

    // Sequencer state, PC, load pointer and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pc            <= RESET_PC;
            r_load_ptr      <= 5'd0;
            r_load_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    // A load request wins over a run request.
                    if (load_start) begin
                        r_state         <= ST_LOAD;
                        r_load_ptr      <= 5'd0;
                        r_load_overflow <= 1'b0;
                    end else if (run_start) begin
                        r_state <= ST_RUN;
                        r_pc    <= RESET_PC;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_load_ptr <= r_load_ptr + 5'd1;
                        if (load_last) begin
                            r_state <= ST_IDLE;
                        end else if (r_load_ptr == 5'd31) begin
                            // Memory is full: the last slot ends the session.
                            r_state         <= ST_IDLE;
                            r_load_overflow <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    // Stall beats halt, halt beats branch, branch beats increment.
                    if (stall) begin
                        r_pc <= r_pc;
                    end else if (w_is_halt) begin
                        r_state <= ST_HALT;
                    end else if (branch_taken) begin
                        r_pc <= {branch_target[6:2], 2'b00};
                    end else begin
                        r_pc <= r_pc + 7'd4;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side and status outputs decoded from the current state and inputs.
    always_comb begin
        load_ready   = 1'b0;
        mem_write_en = 1'b0;
        mem_mode     = 1'b0;
        mem_addr     = 5'd0;
        mem_data     = 32'd0;
        instr_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mem_addr = 5'd0;
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                mem_mode   = 1'b1;
                mem_addr   = r_load_ptr;
                if (w_accept) begin
                    mem_write_en = 1'b1;
                    mem_data     = load_data;
                end else begin
                    mem_write_en = 1'b0;
                end
            end
            ST_RUN: begin
                mem_addr    = r_pc[6:2];
                instr_valid = !stall;
            end
            ST_HALT: begin
                mem_addr = r_pc[6:2];
            end
            default: begin
                mem_addr = 5'd0;
            end
        endcase
    end

    assign pc            = r_pc;
    assign state         = r_state;
    assign load_overflow = r_load_overflow;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus tasks push expected memory
// writes and fetches into queues, a negedge monitor pops and compares them.
module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, load_valid, load_last, load_ready;
    logic [31:0] load_data;
    logic        run_start, stall, branch_taken;
    logic [6:0]  branch_target;
    logic [31:0] instruction;
    logic        mem_write_en, mem_mode;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic [6:0]  pc;
    logic        instr_valid;
    logic [1:0]  state;
    logic        load_overflow;

    fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .run_start(run_start), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .instruction(instruction),
        .mem_write_en(mem_write_en), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_data(mem_data), .pc(pc), .instr_valid(instr_valid),
        .state(state), .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;

    // Instruction memory attached to the DUT (asynchronous read).
    logic [31:0] tb_mem [32] = '{default: 32'd0};
    assign instruction = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write_en === 1'b1) tb_mem[mem_addr] <= mem_data;
    end

    // Reference model state.
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t         wq[$];
    logic [6:0]  fq[$];
    logic [31:0] ref_mem [32];
    logic [4:0]  m_ptr;
    bit          m_in_load;
    bit          m_ovf;
    bit          m_halt;
    logic [6:0]  mpc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe and every valid fetch must match the next queued expectation.
    always @(negedge clk) begin : mon
        wr_t        w;
        logic [6:0] p;
        if (mem_write_en === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(mem_addr) | 32'h100, 32'h0);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w.addr));
                chk("wr_data", mem_data, w.data);
            end
        end
        if (instr_valid === 1'b1) begin
            if (fq.size() == 0) begin
                chk("unexpected_fetch", 32'(pc) | 32'h100, 32'h0);
            end else begin
                p = fq.pop_front();
                chk("fetch_pc", 32'(pc), 32'(p));
                chk("fetch_addr", 32'(mem_addr), 32'(p[6:2]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(2'd0));
        chk({tag, "_pc"}, 32'(pc), 32'(7'd0));
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd0);
        chk({tag, "_write_en"}, 32'(mem_write_en), 32'd0);
        chk({tag, "_mem_mode"}, 32'(mem_mode), 32'd0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_overflow"}, 32'(load_overflow), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_data"}, mem_data, 32'd0);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_in_load = 1'b1;
        m_ptr     = 5'd0;
        m_ovf     = 1'b0;
        chk("load_entry_state", 32'(state), 32'(2'd1));
        chk("load_entry_overflow", 32'(load_overflow), 32'd0);
    endtask

    task automatic load_word(input logic [31:0] d, input bit last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        if (m_in_load) begin
            wq.push_back('{addr: m_ptr, data: d});
            ref_mem[m_ptr] = d;
        end
        @(negedge clk);
        chk("load_ready", 32'(load_ready), 32'(m_in_load));
        chk("mem_mode_load", 32'(mem_mode), 32'(m_in_load));
        if (m_in_load) begin
            if (last) begin
                m_in_load = 1'b0;
            end else if (m_ptr == 5'd31) begin
                m_in_load = 1'b0;
                m_ovf     = 1'b1;
            end
            m_ptr = m_ptr + 5'd1;
        end
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic check_load_done(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(m_in_load ? 2'd1 : 2'd0));
        chk({tag, "_overflow"}, 32'(load_overflow), 32'(m_ovf));
        chk({tag, "_writes_drained"}, 32'(wq.size()), 32'd0);
    endtask

    task automatic start_run();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        mpc    = 7'd0;
        m_halt = 1'b0;
        chk("run_entry_state", 32'(state), 32'(2'd2));
        chk("run_entry_pc", 32'(pc), 32'(7'd0));
    endtask

    task automatic run_cycle(input bit st, input bit br, input logic [6:0] tgt, input bit ls);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        load_start    = ls;
        if (!m_halt && !st) fq.push_back(mpc);
        @(negedge clk);
        chk("run_pc", 32'(pc), 32'(mpc));
        chk("run_state", 32'(state), 32'(m_halt ? 2'd3 : 2'd2));
        chk("run_instr_valid", 32'(instr_valid), 32'(!m_halt && !st));
        if (!m_halt && !st) begin
            if (ref_mem[mpc[6:2]] == HALT) m_halt = 1'b1;
            else if (br) mpc = {tgt[6:2], 2'b00};
            else mpc = mpc + 7'd4;
        end
        tick();
        stall        = 1'b0;
        branch_taken = 1'b0;
        load_start   = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] d;
        d = $urandom();
        if (d == HALT) d = 32'd0;
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        load_start = 1'b0; load_valid = 1'b0; load_data = 32'd0; load_last = 1'b0;
        run_start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 7'd0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
        m_ptr = 5'd0; m_in_load = 1'b0; m_ovf = 1'b0; m_halt = 1'b0; mpc = 7'd0;
        #12;
        check_idle_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // Three-word program, last on the third word.
        start_load();
        load_word(32'hAAAA_0001, 1'b0);
        load_word(32'hBBBB_0002, 1'b0);
        load_word(32'hCCCC_0003, 1'b1);
        check_load_done("abc");

        // 33 words without last: 32 writes, overflow, 33rd ignored.
        start_load();
        for (int i = 0; i < 33; i++) load_word(rand_word(), 1'b0);
        check_load_done("overflow");
        chk("overflow_load_ready", 32'(load_ready), 32'd0);

        // Full 32-word program free of halt words.
        start_load();
        for (int i = 0; i < 32; i++) load_word(rand_word(), i == 31);
        check_load_done("full");

        // Straight-line fetch, wrap past 124, stall+branch then branch alone.
        start_run();
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 7'd0, 1'b0);
        run_cycle(1'b0, 1'b1, 7'd122, 1'b0);
        run_cycle(1'b0, 1'b0, 7'd0, 1'b0);
        run_cycle(1'b0, 1'b0, 7'd0, 1'b0);
        run_cycle(1'b0, 1'b0, 7'd0, 1'b0);
        run_cycle(1'b1, 1'b1, 7'd41, 1'b0);
        run_cycle(1'b0, 1'b1, 7'd41, 1'b0);
        run_cycle(1'b0, 1'b0, 7'd0, 1'b0);
        chk("branch_then_inc_pc", 32'(pc), 32'(7'd44));

        // Random stall / branch / ignored load_start traffic.
        for (int i = 0; i < 150; i++) begin
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                      7'($urandom_range(0, 127)), $urandom_range(0, 9) == 0);
        end
        chk("random_fetches_drained", 32'(fq.size()), 32'd0);

        // Return to idle, then a program that halts at pc=8.
        rst = 1'b1;
        #1;
        check_idle_outputs("midrun_reset");
        tick();
        rst = 1'b0;
        m_halt = 1'b0; mpc = 7'd0;
        tick();
        start_load();
        load_word(rand_word(), 1'b0);
        load_word(rand_word(), 1'b0);
        load_word(HALT, 1'b0);
        load_word(rand_word(), 1'b1);
        check_load_done("halt_prog");

        start_run();
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 7'd0, 1'b0);
        chk("halt_state", 32'(state), 32'(2'd3));
        chk("halt_pc", 32'(pc), 32'(7'd8));
        for (int i = 0; i < 4; i++)
            run_cycle($urandom_range(0, 1) == 1, 1'b1, 7'($urandom_range(0, 127)), 1'b0);
        start_run();
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 7'd0, 1'b0);
        chk("rehalt_pc", 32'(pc), 32'(7'd8));

        // Reset in the middle of a load session (from HALT with pc=8).
        start_load();
        load_word(32'h1234_5678, 1'b0);
        load_word(32'h9ABC_DEF0, 1'b0);
        load_valid = 1'b1;
        load_data  = 32'h0BAD_0BAD;
        #2;
        rst = 1'b1;
        #1;
        chk("midload_rst_state", 32'(state), 32'(2'd0));
        chk("midload_rst_write_en", 32'(mem_write_en), 32'd0);
        chk("midload_rst_load_ready", 32'(load_ready), 32'd0);
        chk("midload_rst_pc", 32'(pc), 32'(7'd0));
        @(negedge clk);
        #2;
        rst = 1'b0;
        load_valid = 1'b0;
        tick();
        tick();
        chk("final_writes_drained", 32'(wq.size()), 32'd0);
        chk("final_fetches_drained", 32'(fq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
